scoreboard_ctrl: RTL and testbench

SCOREBOARD_CTRL -- requirements
Module: scoreboard_ctrl

---
 rtl/scoreboard_ctrl.sv | 112 +++++++++++
 tb/tb_scoreboard_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/scoreboard_ctrl.sv
// Register scoreboard: per-register pending-write counters, RAW/WAW stall and drain sequencing.
// Optional macro SCOREBOARD_WB_BYPASS_EN lets a source whose last pending write retires this cycle issue.
module scoreboard_ctrl #(
    parameter int NREGS     = 32,
    parameter int REGNOBITS = 5,
    parameter int CNTBITS   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 de_valid,
    input  logic                 de_rs1_rd,
    input  logic                 de_rs2_rd,
    input  logic [REGNOBITS-1:0] de_rs1,
    input  logic [REGNOBITS-1:0] de_rs2,
    input  logic                 de_wr_reg,
    input  logic [REGNOBITS-1:0] de_rd,
    input  logic                 flush,
    input  logic                 wb_wr_reg,
    input  logic [REGNOBITS-1:0] wb_regno,
    input  logic                 drain_req,
    output logic                 stall,
    output logic                 issue,
    output logic [NREGS-1:0]     busy_bits,
    output logic                 drain_done,
    output logic                 underflow_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [CNTBITS-1:0] CNT_MAX = '1;
    localparam logic [CNTBITS-1:0] CNT_ONE = CNTBITS'(1);

    state_t               state_q, state_d;
    logic [CNTBITS-1:0]   cnt_q [NREGS];
    logic [CNTBITS-1:0]   cnt_d [NREGS];
    logic [NREGS-1:0]     busy_q, busy_d;
    logic                 drain_done_q, drain_done_d;
    logic                 underflow_q, underflow_d;

    logic [CNTBITS-1:0]   cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;
    logic                 raw1, raw2, waw;
    logic                 inc_en, dec_req, dec_en, inc_i, dec_i;

    always_comb begin
        cnt_rs1 = cnt_q[de_rs1];
        cnt_rs2 = cnt_q[de_rs2];
        cnt_rd  = cnt_q[de_rd];
        cnt_wb  = cnt_q[wb_regno];

        raw1 = de_rs1_rd && (de_rs1 != '0) && (cnt_rs1 != '0);
        raw2 = de_rs2_rd && (de_rs2 != '0) && (cnt_rs2 != '0);
`ifdef SCOREBOARD_WB_BYPASS_EN
        // Regfile writes on negedge, so the retiring value is readable in DE this cycle.
        if (wb_wr_reg && (wb_regno == de_rs1) && (cnt_rs1 == CNT_ONE)) raw1 = 1'b0;
        if (wb_wr_reg && (wb_regno == de_rs2) && (cnt_rs2 == CNT_ONE)) raw2 = 1'b0;
`endif
        waw = de_wr_reg && (cnt_rd == CNT_MAX);

        stall = (state_q != ST_IDLE) || (de_valid && (raw1 || raw2 || waw));
        issue = de_valid && !stall && !flush;

        inc_en  = issue && de_wr_reg && (de_rd != '0);
        dec_req = wb_wr_reg && (wb_regno != '0);
        dec_en  = dec_req && (cnt_wb != '0);
        underflow_d = underflow_q || (dec_req && (cnt_wb == '0));

        busy_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            inc_i    = inc_en && (de_rd == REGNOBITS'(i));
            dec_i    = dec_en && (wb_regno == REGNOBITS'(i));
            cnt_d[i] = cnt_q[i];
            if (inc_i && !dec_i)      cnt_d[i] = cnt_q[i] + CNT_ONE;
            else if (dec_i && !inc_i) cnt_d[i] = cnt_q[i] - CNT_ONE;
            if (i == 0) cnt_d[i] = '0;
            busy_d[i] = (cnt_d[i] != '0);
        end

        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (drain_req) state_d = ST_DRAIN;
            ST_DRAIN: if (busy_d == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        drain_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            busy_q       <= '0;
            drain_done_q <= 1'b0;
            underflow_q  <= 1'b0;
            for (int i = 0; i < NREGS; i++) cnt_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            drain_done_q <= drain_done_d;
            underflow_q  <= underflow_d;
            for (int i = 0; i < NREGS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign busy_bits     = busy_q;
    assign drain_done    = drain_done_q;
    assign underflow_err = underflow_q;

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Directed self-checking bench for scoreboard_ctrl (default parameters).
module tb_scoreboard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        de_valid, de_rs1_rd, de_rs2_rd, de_wr_reg, flush, wb_wr_reg, drain_req;
    logic [4:0]  de_rs1, de_rs2, de_rd, wb_regno;
    logic        stall, issue, drain_done, underflow_err;
    logic [31:0] busy_bits;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scoreboard_ctrl dut (
        .clk(clk), .reset(reset),
        .de_valid(de_valid), .de_rs1_rd(de_rs1_rd), .de_rs2_rd(de_rs2_rd),
        .de_rs1(de_rs1), .de_rs2(de_rs2), .de_wr_reg(de_wr_reg), .de_rd(de_rd),
        .flush(flush), .wb_wr_reg(wb_wr_reg), .wb_regno(wb_regno), .drain_req(drain_req),
        .stall(stall), .issue(issue), .busy_bits(busy_bits),
        .drain_done(drain_done), .underflow_err(underflow_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        de_valid = 0; de_rs1_rd = 0; de_rs2_rd = 0; de_wr_reg = 0; flush = 0;
        wb_wr_reg = 0; drain_req = 0; de_rs1 = 0; de_rs2 = 0; de_rd = 0; wb_regno = 0;
    endtask

    // advance one rising edge, land 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        clr();
        reset = 1;
        tick(); tick();
        reset = 0;
        settle();
        chk("rst_busy", busy_bits, 32'h0);
        chk("rst_done", {31'b0, drain_done}, 32'h0);
        chk("rst_uflow", {31'b0, underflow_err}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_issue", {31'b0, issue}, 32'h0);

        // RAW on x5
        de_valid = 1; de_wr_reg = 1; de_rd = 5; settle();
        chk("raw_issue_wr", {31'b0, issue}, 32'h1);
        tick();
        chk("raw_busy5", busy_bits, 32'h0000_0020);
        de_wr_reg = 0; de_rs1_rd = 1; de_rs1 = 5; settle();
        chk("raw_stall", {31'b0, stall}, 32'h1);
        chk("raw_noissue", {31'b0, issue}, 32'h0);
        de_valid = 0; wb_wr_reg = 1; wb_regno = 5; settle();
        chk("raw_novalid_stall", {31'b0, stall}, 32'h0);
        tick();
        chk("raw_busy_clr", busy_bits, 32'h0);
        wb_wr_reg = 0; de_valid = 1; settle();
        chk("raw_stall_clr", {31'b0, stall}, 32'h0);
        chk("raw_issue_clr", {31'b0, issue}, 32'h1);
        de_rs1 = 0; de_rs1_rd = 0;

        // WAW limit on x7
        clr(); de_valid = 1; de_wr_reg = 1; de_rd = 7;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("waw_issue", {31'b0, issue}, 32'h1);
            tick();
        end
        chk("waw_busy7", busy_bits, 32'h0000_0080);
        chk("waw_stall_max", {31'b0, stall}, 32'h1);
        chk("waw_noissue_max", {31'b0, issue}, 32'h0);
        de_valid = 0; wb_wr_reg = 1; wb_regno = 7; tick();
        wb_wr_reg = 0; de_valid = 1; settle();
        chk("waw_stall_drop", {31'b0, stall}, 32'h0);
        de_valid = 0; wb_wr_reg = 1; tick(); tick();
        wb_wr_reg = 0; settle();
        chk("waw_busy_clr", busy_bits, 32'h0);
        chk("waw_no_uflow", {31'b0, underflow_err}, 32'h0);

        // flush squashes issue
        clr(); de_valid = 1; de_wr_reg = 1; de_rd = 3; flush = 1; settle();
        chk("flush_issue", {31'b0, issue}, 32'h0);
        tick();
        chk("flush_busy", busy_bits, 32'h0);

        // drain with x9 pending
        clr(); de_valid = 1; de_wr_reg = 1; de_rd = 9; tick();
        chk("drain_busy9", busy_bits, 32'h0000_0200);
        clr(); drain_req = 1; tick();
        drain_req = 0; de_valid = 1; settle();
        chk("drain_stall1", {31'b0, stall}, 32'h1);
        chk("drain_noissue", {31'b0, issue}, 32'h0);
        chk("drain_done_lo", {31'b0, drain_done}, 32'h0);
        tick();
        chk("drain_stall2", {31'b0, stall}, 32'h1);
        chk("drain_wait_done", {31'b0, drain_done}, 32'h0);
        wb_wr_reg = 1; wb_regno = 9; settle();
        chk("drain_stall_wb", {31'b0, stall}, 32'h1);
        tick();
        wb_wr_reg = 0; drain_req = 1; settle();
        chk("drain_done_hi", {31'b0, drain_done}, 32'h1);
        chk("drain_done_stall", {31'b0, stall}, 32'h1);
        chk("drain_busy_clr", busy_bits, 32'h0);
        tick();
        drain_req = 0; settle();
        chk("drain_done_pulse", {31'b0, drain_done}, 32'h0);
        chk("drain_idle_stall", {31'b0, stall}, 32'h0);
        chk("drain_idle_issue", {31'b0, issue}, 32'h1);

        // underflow and rd=0
        clr(); wb_wr_reg = 1; wb_regno = 4; tick();
        chk("uflow_set", {31'b0, underflow_err}, 32'h1);
        chk("uflow_busy", busy_bits, 32'h0);
        clr(); de_valid = 1; de_wr_reg = 1; de_rd = 0; settle();
        chk("rd0_issue", {31'b0, issue}, 32'h1);
        tick();
        chk("rd0_busy", busy_bits, 32'h0);
        clr(); tick();
        chk("uflow_sticky", {31'b0, underflow_err}, 32'h1);

        // WB bypass on rs2=x6
        de_valid = 1; de_wr_reg = 1; de_rd = 6; tick();
        clr(); de_valid = 1; de_rs2_rd = 1; de_rs2 = 6; wb_wr_reg = 1; wb_regno = 6; settle();
`ifdef SCOREBOARD_WB_BYPASS_EN
        chk("byp_stall", {31'b0, stall}, 32'h0);
`else
        chk("byp_stall", {31'b0, stall}, 32'h1);
`endif
        tick();
        chk("byp_busy_clr", busy_bits, 32'h0);

        // reset priority over issue and drain_req
        clr(); de_valid = 1; de_wr_reg = 1; de_rd = 10; drain_req = 1; reset = 1; tick();
        reset = 0; clr(); de_valid = 1; settle();
        chk("rstp_busy", busy_bits, 32'h0);
        chk("rstp_uflow", {31'b0, underflow_err}, 32'h0);
        chk("rstp_idle_stall", {31'b0, stall}, 32'h0);

        // simultaneous inc and dec on x11 keeps counter at 1
        de_wr_reg = 1; de_rd = 11; tick();
        wb_wr_reg = 1; wb_regno = 11; tick();
        chk("incdec_busy", busy_bits, 32'h0000_0800);
        clr(); wb_wr_reg = 1; wb_regno = 11; tick();
        chk("incdec_clr", busy_bits, 32'h0);
        chk("incdec_no_uflow", {31'b0, underflow_err}, 32'h0);

        clr(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
